// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one single-port memory between instruction and data requesters.
// Read done at T+2+LATENCY, write done at T+2; requesters hold req until done, stall_* freeze the pipe.
module mem_port_arbiter #(
    parameter int ADDR_W  = 32,
    parameter int MEM_AW  = 10,
    parameter int LATENCY = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic              i_flush,
    output logic [31:0]       i_rdata,
    output logic              i_done,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [31:0]       d_wdata,
    output logic [31:0]       d_rdata,
    output logic              d_done,
    output logic              m_en,
    output logic              m_we,
    output logic [MEM_AW-1:0] m_addr,
    output logic [31:0]       m_wdata,
    input  logic [31:0]       m_rdata,
    output logic              stall_f,
    output logic              stall_m,
    output logic              busy
);
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

    // LATENCY must lie in 1..15 so that LATENCY-1 fits the 4-bit wait counter.
    localparam logic [3:0] LAT_M1 = 4'(LATENCY - 1);

    state_t            state, state_nx;
    logic              gnt_d, gnt_d_nx;   // current / last grant, 1 = data port
    logic              kill, kill_nx;
    logic [3:0]        cnt, cnt_nx;
    logic              pick_d, kill_eff;
    logic              m_en_nx, m_we_nx, i_done_nx, d_done_nx, busy_nx;
    logic [MEM_AW-1:0] m_addr_nx;
    logic [31:0]       m_wdata_nx, i_rdata_nx, d_rdata_nx;
    logic              unused_addr;

    assign unused_addr = ^{i_addr[ADDR_W-1:MEM_AW+2], i_addr[1:0],
                           d_addr[ADDR_W-1:MEM_AW+2], d_addr[1:0]};

    assign stall_f = i_req & ~i_done;
    assign stall_m = d_req & ~d_done;

    always_comb begin
        state_nx   = state;
        gnt_d_nx   = gnt_d;
        kill_nx    = kill;
        cnt_nx     = cnt;
        m_en_nx    = 1'b0;
        m_we_nx    = m_we;
        m_addr_nx  = m_addr;
        m_wdata_nx = m_wdata;
        i_rdata_nx = i_rdata;
        d_rdata_nx = d_rdata;
        i_done_nx  = 1'b0;
        d_done_nx  = 1'b0;
        // On a tie the port that did not win last time gets the memory.
        pick_d     = d_req & (~i_req | ~gnt_d);
        kill_eff   = kill | (~gnt_d & i_flush);
        case (state)
            IDLE: begin
                if (i_req | d_req) begin
                    gnt_d_nx   = pick_d;
                    m_addr_nx  = pick_d ? d_addr[MEM_AW+1:2] : i_addr[MEM_AW+1:2];
                    m_we_nx    = pick_d & d_we;
                    m_wdata_nx = d_wdata;
                    m_en_nx    = 1'b1;
                    kill_nx    = 1'b0;
                    state_nx   = ISSUE;
                end
            end
            ISSUE: begin
                kill_nx = kill_eff;
                if (m_we) begin
                    d_done_nx = 1'b1;
                    state_nx  = DONE;
                end else begin
                    cnt_nx   = LAT_M1;
                    state_nx = WAIT;
                end
            end
            WAIT: begin
                kill_nx = kill_eff;
                if (cnt == 4'd0) begin
                    state_nx = DONE;
                    if (gnt_d) begin
                        d_rdata_nx = m_rdata;
                        d_done_nx  = 1'b1;
                    end else if (!kill_eff) begin
                        i_rdata_nx = m_rdata;
                        i_done_nx  = 1'b1;
                    end
                end else begin
                    cnt_nx = cnt - 4'd1;
                end
            end
            DONE: begin
                kill_nx  = kill_eff;
                state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
        busy_nx = (state_nx != IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            gnt_d   <= 1'b0;
            kill    <= 1'b0;
            cnt     <= 4'd0;
            m_en    <= 1'b0;
            m_we    <= 1'b0;
            m_addr  <= '0;
            m_wdata <= '0;
            i_rdata <= '0;
            d_rdata <= '0;
            i_done  <= 1'b0;
            d_done  <= 1'b0;
            busy    <= 1'b0;
        end else begin
            state   <= state_nx;
            gnt_d   <= gnt_d_nx;
            kill    <= kill_nx;
            cnt     <= cnt_nx;
            m_en    <= m_en_nx;
            m_we    <= m_we_nx;
            m_addr  <= m_addr_nx;
            m_wdata <= m_wdata_nx;
            i_rdata <= i_rdata_nx;
            d_rdata <= d_rdata_nx;
            i_done  <= i_done_nx;
            d_done  <= d_done_nx;
            busy    <= busy_nx;
        end
    end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: instance 0 with LATENCY=1, instance 1 with LATENCY=3, each with a bench memory.
// A cycle-count transaction model is compared every cycle, plus directed literal expectations.
module tb_mem_port_arbiter;
    logic              clk = 1'b0;
    logic [1:0]        rst, i_req, i_flush, d_req, d_we;
    logic [1:0][31:0]  i_addr, d_addr, d_wdata, m_rdata;
    logic [1:0][31:0]  i_rdata, d_rdata, m_wdata;
    logic [1:0]        i_done, d_done, m_en, m_we, stall_f, stall_m, busy;
    logic [1:0][9:0]   m_addr;

    logic [31:0] mem  [2][1024];
    logic [31:0] pipe [2][16];
    logic [31:0] mmod [2][1024];

    int cyc = 0;
    int n_chk = 0;
    int n_fail = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    mem_port_arbiter #(.ADDR_W(32), .MEM_AW(10), .LATENCY(1)) u_dut0 (
        .clk(clk), .rst(rst[0]), .i_req(i_req[0]), .i_addr(i_addr[0]), .i_flush(i_flush[0]),
        .i_rdata(i_rdata[0]), .i_done(i_done[0]), .d_req(d_req[0]), .d_we(d_we[0]),
        .d_addr(d_addr[0]), .d_wdata(d_wdata[0]), .d_rdata(d_rdata[0]), .d_done(d_done[0]),
        .m_en(m_en[0]), .m_we(m_we[0]), .m_addr(m_addr[0]), .m_wdata(m_wdata[0]),
        .m_rdata(m_rdata[0]), .stall_f(stall_f[0]), .stall_m(stall_m[0]), .busy(busy[0]));

    mem_port_arbiter #(.ADDR_W(32), .MEM_AW(10), .LATENCY(3)) u_dut1 (
        .clk(clk), .rst(rst[1]), .i_req(i_req[1]), .i_addr(i_addr[1]), .i_flush(i_flush[1]),
        .i_rdata(i_rdata[1]), .i_done(i_done[1]), .d_req(d_req[1]), .d_we(d_we[1]),
        .d_addr(d_addr[1]), .d_wdata(d_wdata[1]), .d_rdata(d_rdata[1]), .d_done(d_done[1]),
        .m_en(m_en[1]), .m_we(m_we[1]), .m_addr(m_addr[1]), .m_wdata(m_wdata[1]),
        .m_rdata(m_rdata[1]), .stall_f(stall_f[1]), .stall_m(stall_m[1]), .busy(busy[1]));

    // Bench memory: read data appears LATENCY cycles after the m_en cycle.
    always @(posedge clk) begin
        for (int k = 0; k < 2; k++) begin
            if (m_en[k] && m_we[k]) mem[k][m_addr[k]] <= m_wdata[k];
            pipe[k][0] <= mem[k][m_addr[k]];
            for (int i = 1; i < 16; i++) pipe[k][i] <= pipe[k][i-1];
        end
    end
    assign m_rdata[0] = pipe[0][0];
    assign m_rdata[1] = pipe[1][2];

    function automatic int lat_of(input int k);
        return (k == 0) ? 1 : 3;
    endfunction

    task automatic chk(input string name, input int k, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s dut%0d cycle %0d: got %h expected %h", name, k, cyc, act, exp);
        end
    endtask

    // Transaction model: per instance, when the next access starts and on which cycle it completes.
    bit          valid [2], active [2], mg_d [2], mkill [2], lastd [2], mwe [2];
    int          done_at [2];
    logic [31:0] rdval [2];
    bit          e_m_en [2], e_m_we [2], e_i_done [2], e_d_done [2], e_busy [2];
    logic [9:0]  e_m_addr [2];
    logic [31:0] e_m_wdata [2], e_i_rdata [2], e_d_rdata [2];
    bit          prev_en [2];

    task automatic model_step(input int k);
        int now;
        bit g;
        logic [31:0] a;
        logic [9:0] w;
        now = cyc;
        if (rst[k]) begin
            valid[k] = 1; active[k] = 0; lastd[k] = 0; mkill[k] = 0;
            e_m_en[k] = 0; e_m_we[k] = 0; e_i_done[k] = 0; e_d_done[k] = 0; e_busy[k] = 0;
            e_m_addr[k] = '0; e_m_wdata[k] = '0; e_i_rdata[k] = '0; e_d_rdata[k] = '0;
        end else if (valid[k]) begin
            e_m_en[k] = 0; e_i_done[k] = 0; e_d_done[k] = 0;
            if (active[k]) begin
                if (!mg_d[k] && i_flush[k] && now < done_at[k]) mkill[k] = 1;
                if (now + 1 == done_at[k]) begin
                    if (mg_d[k]) begin
                        e_d_done[k] = 1;
                        if (!mwe[k]) e_d_rdata[k] = rdval[k];
                    end else if (!mkill[k]) begin
                        e_i_done[k] = 1;
                        e_i_rdata[k] = rdval[k];
                    end
                end
                if (now == done_at[k]) active[k] = 0;
            end else if (i_req[k] || d_req[k]) begin
                g = d_req[k] && (!i_req[k] || !lastd[k]);
                lastd[k] = g; mg_d[k] = g; active[k] = 1; mkill[k] = 0;
                a = g ? d_addr[k] : i_addr[k];
                w = a[11:2];
                mwe[k] = g && d_we[k];
                done_at[k] = now + 2 + (mwe[k] ? 0 : lat_of(k));
                e_m_en[k] = 1; e_m_addr[k] = w; e_m_we[k] = mwe[k]; e_m_wdata[k] = d_wdata[k];
                if (mwe[k]) mmod[k][w] = d_wdata[k];
                else rdval[k] = mmod[k][w];
            end
            e_busy[k] = active[k];
        end
    endtask

    initial begin
        forever begin
            @(negedge clk);
            for (int k = 0; k < 2; k++) begin
                if (valid[k]) begin
                    chk("m_en", k, m_en[k], e_m_en[k]);
                    chk("m_we", k, m_we[k], e_m_we[k]);
                    chk("m_addr", k, m_addr[k], e_m_addr[k]);
                    chk("m_wdata", k, m_wdata[k], e_m_wdata[k]);
                    chk("i_done", k, i_done[k], e_i_done[k]);
                    chk("d_done", k, d_done[k], e_d_done[k]);
                    chk("i_rdata", k, i_rdata[k], e_i_rdata[k]);
                    chk("d_rdata", k, d_rdata[k], e_d_rdata[k]);
                    chk("busy", k, busy[k], e_busy[k]);
                    chk("stall_f", k, stall_f[k], i_req[k] & ~e_i_done[k]);
                    chk("stall_m", k, stall_m[k], d_req[k] & ~e_d_done[k]);
                    chk("done_excl", k, i_done[k] & d_done[k], 1'b0);
                    chk("en_b2b", k, m_en[k] & prev_en[k], 1'b0);
                end
                prev_en[k] = m_en[k];
                model_step(k);
            end
        end
    end

    // One access on port (pd=1 data); returns cycles from request to done pulse.
    task automatic acc(input int k, input bit pd, input bit we, input logic [31:0] addr,
                       input logic [31:0] wd, output int lat);
        int start;
        bit got;
        start = cyc; got = 0; lat = -1;
        if (pd) begin
            d_req[k] = 1; d_we[k] = we; d_addr[k] = addr; d_wdata[k] = wd;
        end else begin
            i_req[k] = 1; i_addr[k] = addr;
        end
        for (int n = 0; n < 60 && !got; n++) begin
            @(negedge clk);
            if (pd ? d_done[k] : i_done[k]) begin
                got = 1;
                lat = cyc - start;
            end
        end
        if (!got) begin
            n_chk++; n_fail++;
            $display("FAIL timeout dut%0d port_d=%0d: no done within 60 cycles", k, pd);
        end
        @(posedge clk); #2;
        if (pd) d_req[k] = 0; else i_req[k] = 0;
    endtask

    int lat_a, lat_b;
    int ld [3], li [3];

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int k = 0; k < 2; k++) begin
            for (int i = 0; i < 1024; i++) begin
                mem[k][i]  = 32'hA000_0000 | i;
                mmod[k][i] = 32'hA000_0000 | i;
            end
        end
        mem[0][5] = 32'hDEAD_BEEF;
        mmod[0][5] = 32'hDEAD_BEEF;
        rst = 2'b11; i_req = '0; i_flush = '0; d_req = '0; d_we = '0;
        i_addr = '0; d_addr = '0; d_wdata = '0;
        repeat (2) @(posedge clk);
        #2 rst = 2'b00;
        @(negedge clk);
        chk("rst_busy", 0, busy[0], 1'b0);
        chk("rst_m_en", 1, m_en[1], 1'b0);
        chk("rst_i_rdata", 0, i_rdata[0], 32'h0);

        // Plain instruction read, LATENCY=1.
        @(posedge clk); #2;
        acc(0, 0, 0, 32'h14, 32'h0, lat_a);
        chk("t1_lat", 0, lat_a, 3);
        chk("t1_rdata", 0, i_rdata[0], 32'hDEAD_BEEF);
        chk("t1_addr", 0, m_addr[0], 10'd5);

        // Simultaneous requests: data write wins the first tie after an instruction grant.
        fork
            acc(0, 1, 1, 32'h40, 32'h1234_5678, lat_a);
            acc(0, 0, 0, 32'h8, 32'h0, lat_b);
        join
        chk("t2_d_lat", 0, lat_a, 2);
        chk("t2_i_lat", 0, lat_b, 6);
        chk("t2_i_rdata", 0, i_rdata[0], 32'hA000_0002);
        chk("t2_mem16", 0, mem[0][16], 32'h1234_5678);

        // Write with unaligned address, read back aligned.
        acc(0, 1, 1, 32'h43, 32'hCAFE_F00D, lat_a);
        chk("t6_w_lat", 0, lat_a, 2);
        acc(0, 1, 0, 32'h40, 32'h0, lat_a);
        chk("t6_r_lat", 0, lat_a, 3);
        chk("t6_d_rdata", 0, d_rdata[0], 32'hCAFE_F00D);

        // Both ports requesting continuously, LATENCY=3: strict alternation, D first.
        fork
            for (int j = 0; j < 3; j++) acc(1, 1, 0, 32'h100 + 4 * j, 32'h0, ld[j]);
            for (int j = 0; j < 3; j++) acc(1, 0, 0, 32'h200 + 4 * j, 32'h0, li[j]);
        join
        chk("t3_d0", 1, ld[0], 5);
        chk("t3_i0", 1, li[0], 11);
        chk("t3_d1", 1, ld[1], 11);
        chk("t3_i2", 1, li[2], 11);
        chk("t3_i_rdata", 1, i_rdata[1], 32'hA000_0082);
        chk("t3_d_rdata", 1, d_rdata[1], 32'hA000_0042);

        // Flush in the second WAIT cycle kills the instruction read.
        i_req[1] = 1; i_addr[1] = 32'h300;
        repeat (3) @(posedge clk);
        #2 i_flush[1] = 1;
        @(posedge clk);
        #2 begin i_flush[1] = 0; i_req[1] = 0; end
        @(posedge clk);
        @(negedge clk);
        chk("t4_busy_done", 1, busy[1], 1'b1);
        chk("t4_no_idone", 1, i_done[1], 1'b0);
        @(negedge clk);
        chk("t4_idle", 1, busy[1], 1'b0);
        chk("t4_i_rdata", 1, i_rdata[1], 32'hA000_0082);
        @(posedge clk); #2;
        acc(1, 1, 0, 32'h10, 32'h0, lat_a);
        chk("t4_d_lat", 1, lat_a, 5);
        chk("t4_d_rdata", 1, d_rdata[1], 32'hA000_0004);

        // Reset during a WAIT cycle abandons the data read.
        d_req[1] = 1; d_we[1] = 0; d_addr[1] = 32'h20;
        repeat (3) @(posedge clk);
        #2 begin rst[1] = 1; d_req[1] = 0; end
        @(posedge clk);
        #2 rst[1] = 0;
        @(negedge clk);
        chk("t5_busy", 1, busy[1], 1'b0);
        chk("t5_m_en", 1, m_en[1], 1'b0);
        chk("t5_d_done", 1, d_done[1], 1'b0);
        @(posedge clk); #2;
        acc(1, 1, 0, 32'h20, 32'h0, lat_a);
        chk("t5_lat", 1, lat_a, 5);
        chk("t5_d_rdata", 1, d_rdata[1], 32'hA000_0008);

        repeat (3) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one single-port word memory between the fetch-stage instruction port (read-only) and the memory-stage data port (read/write).
- Serialises accesses with a req/done handshake and drives fixed-latency memory control.
- Produces stall signals that feed the hazard logic, so fetch and memory stages freeze until their access completes.
- Sits between the pipeline stages and a unified memory, replacing the separate instruction and data memories.

Parameters:
ADDR_W, 32, byte-address width of the requester ports
MEM_AW, 10, word-address width of the memory port
LATENCY, 1, memory read latency in cycles (legal 1..15)

Ports:
clk  in  1  clock
rst  in  1  synchronous reset, active-high
i_req  in  1  instruction read request; held until i_done
i_addr  in  ADDR_W  instruction byte address
i_flush  in  1  pipeline flush; kills an in-flight instruction read
i_rdata  out  32  instruction read data, valid while i_done=1
i_done  out  1  one-cycle completion pulse, instruction port
d_req  in  1  data request; held until d_done
d_we  in  1  1=write, 0=read; stable while d_req=1
d_addr  in  ADDR_W  data byte address
d_wdata  in  32  write data
d_rdata  out  32  data read data, valid while d_done=1
d_done  out  1  one-cycle completion pulse, data port
m_en  out  1  memory access strobe, one cycle per access
m_we  out  1  memory write enable, qualified by m_en
m_addr  out  MEM_AW  memory word address
m_wdata  out  32  memory write data
m_rdata  in  32  memory read data, valid LATENCY cycles after the m_en cycle
stall_f  out  1  i_req & ~i_done (combinational)
stall_m  out  1  d_req & ~d_done (combinational)
busy  out  1  state != IDLE

Behaviour:
- Reset: synchronous, active-high, and wins over all other events.
  - State goes to IDLE; last_gnt goes to INSTR.
  - m_en, m_we, i_done and d_done are 0; m_addr, m_wdata, i_rdata, d_rdata, counter and kill flag are 0.
- Reset mid-access: the access is abandoned, no done pulse is issued, and m_en is low in the following cycle.
- All outputs except stall_f and stall_m are registered.
- States: IDLE, ISSUE, WAIT, DONE.
- IDLE:
  - Only d_req: grant DATA. Only i_req: grant INSTR.
  - Both requests: grant the port not equal to last_gnt (round-robin), so the first tie after reset goes to DATA.
  - On a grant:
    - Register m_addr = addr[MEM_AW+1:2] (addr[1:0] ignored).
    - Register m_we = (grant==DATA) & d_we and m_wdata = d_wdata.
    - Set m_en=1, set last_gnt = grant, clear the kill flag, go to ISSUE.
  - No request: stay in IDLE.
- ISSUE (m_en=1 for exactly this cycle):
  - Write: go to DONE.
  - Read: load counter = LATENCY-1, go to WAIT.
- WAIT:
  - When counter==0, capture m_rdata into the granted port's rdata register and go to DONE; otherwise decrement the counter.
- DONE:
  - Pulse the done output of the granted port for one cycle; go to IDLE.
  - A write pulses d_done with d_rdata unchanged.
- Latency from request seen in IDLE (cycle T):
  - Read: m_en at T+1, done at T+2+LATENCY.
  - Write: done at T+2.
- Handshake:
  - A requester keeps req, address and data stable until its done pulse.
  - It may drop req or present a new request in the cycle after done.
  - The DONE→IDLE transition guarantees the request just completed is never re-granted on its own done cycle.
- i_flush:
  - If asserted in any cycle of ISSUE, WAIT or DONE while the grant is INSTR, the kill flag is set (or i_done is gated in that DONE cycle).
  - The memory access still completes, but i_done is suppressed and i_rdata is not updated.
  - i_flush has no effect on data-port accesses.
  - i_flush in IDLE has no effect; the fetch stage deasserts or changes i_req itself.
- Back-to-back:
  - With both ports continuously requesting, grants strictly alternate.
  - Each access occupies LATENCY+3 cycles for a read and 3 cycles for a write; no port starves.
- i_done and d_done are never high in the same cycle; m_en is never high in two consecutive cycles.
- The counter is 4 bits wide; LATENCY outside 1..15 is a configuration error.

Test Plan:
1. LATENCY=1, memory word 5 = 0xDEADBEEF, i_req=1 with i_addr=0x14 at cycle 0 → m_en=1 and m_addr=5 at cycle 1; i_done=1 and i_rdata=0xDEADBEEF at cycle 3; stall_f=1 during cycles 0–2.
2. LATENCY=1, i_req and d_req both rise at cycle 0 (data write of 0x12345678 to address 0x40) → data granted first: m_we=1, m_addr=16 at cycle 1, d_done at cycle 2. Instruction granted at cycle 3: m_en at cycle 4, i_done at cycle 6.
3. LATENCY=3, both ports held requesting with new addresses after each done → grants alternate D,I,D,I; reads complete every 6 cycles; m_en is never asserted in consecutive cycles.
4. LATENCY=3, instruction read issued with i_flush=1 pulsed in the second WAIT cycle → no i_done pulse, i_rdata unchanged, state returns to IDLE on schedule; a following d_req is granted normally.
5. rst=1 in a WAIT cycle of a data read → next cycle state is IDLE with busy=0, m_en=0 and no d_done. A re-asserted d_req after reset completes at T+2+LATENCY.
6. Data write of 0xCAFEF00D to address 0x43, then data read of address 0x40 → the memory write happens at word 16, and the read returns d_rdata=0xCAFEF00D.
